// File: rtl/apb_burst_master.sv
// apb_burst_master: APB initiator issuing word bursts for a command port, with valid/ready write and read data streams
// Ports: iClk/iRst clock and sync active-high reset; iCmd* command port (oCmdReady handshake);
//   iWr*/oWrReady write-data stream; oRd*/iRdReady read-data stream; oP*/iPrdata/iPready APB bus;
//   oBusy accept..DONE, oDone end-of-command pulse, oErr timeout-abort pulse (with oDone).
module apb_burst_master #(
  parameter int TIMEOUT_CYC = 255
) (
  input  logic        iClk,
  input  logic        iRst,
  input  logic        iCmdValid,
  output logic        oCmdReady,
  input  logic        iCmdWrite,
  input  logic [15:0] iCmdAddr,
  input  logic [9:0]  iCmdLen,
  input  logic        iWrValid,
  output logic        oWrReady,
  input  logic [31:0] iWrData,
  output logic        oRdValid,
  input  logic        iRdReady,
  output logic [31:0] oRdData,
  output logic        oPsel,
  output logic        oPenable,
  output logic        oPwrite,
  output logic [15:0] oPaddr,
  output logic [31:0] oPwdata,
  input  logic [31:0] iPrdata,
  input  logic        iPready,
  output logic        oBusy,
  output logic        oDone,
  output logic        oErr
);
  typedef enum logic [2:0] {IDLE, WAIT_WD, SETUP, ACCESS, RD_HOLD, DONE} state_t;
  localparam logic [7:0] TO_LAST = 8'(TIMEOUT_CYC - 1);
  state_t state, stateNext;
  logic [15:0] rAddr;
  logic        rWrite;
  logic [9:0]  rRemain;
  logic [7:0]  rTo;
  logic        rErr;
  logic        cmdFire, timeout, wordDone, lastWord;
  assign cmdFire  = state == IDLE && iCmdValid;
  assign timeout  = state == ACCESS && !iPready && rTo == TO_LAST;
  assign wordDone = (state == ACCESS && iPready && rWrite) || (state == RD_HOLD && iRdReady);
  assign lastWord = rRemain == 10'd1;
  // every output is decoded from registered state or held in a register
  assign oCmdReady = state == IDLE;
  assign oWrReady  = state == WAIT_WD;
  assign oRdValid  = state == RD_HOLD;
  assign oPsel     = state == SETUP || state == ACCESS;
  assign oPenable  = state == ACCESS;
  assign oPwrite   = rWrite;
  assign oPaddr    = rAddr;
  assign oBusy     = state != IDLE;
  assign oDone     = state == DONE;
  assign oErr      = state == DONE && rErr;
  always_comb begin
    stateNext = state;
    case (state)
      IDLE:    stateNext = !cmdFire ? IDLE : iCmdLen == 10'd0 ? DONE : iCmdWrite ? WAIT_WD : SETUP;
      WAIT_WD: stateNext = iWrValid ? SETUP : WAIT_WD;
      SETUP:   stateNext = ACCESS;
      ACCESS:  stateNext = timeout ? DONE : !iPready ? ACCESS : !rWrite ? RD_HOLD : lastWord ? DONE : WAIT_WD;
      RD_HOLD: stateNext = !iRdReady ? RD_HOLD : lastWord ? DONE : SETUP;
      DONE:    stateNext = IDLE;
      default: stateNext = IDLE;
    endcase
  end
  always_ff @(posedge iClk) begin
    if (iRst) begin
      state   <= IDLE;
      rAddr   <= '0;
      rWrite  <= 1'b0;
      rRemain <= '0;
      rTo     <= '0;
      rErr    <= 1'b0;
      oPwdata <= '0;
      oRdData <= '0;
    end else begin
      state <= stateNext;
      rTo   <= (state == ACCESS && !iPready && !timeout) ? rTo + 8'd1 : 8'd0;
      if (cmdFire) begin
        rAddr   <= iCmdAddr & 16'hFFFC;
        rWrite  <= iCmdWrite;
        rRemain <= iCmdLen > 10'd512 ? 10'd512 : iCmdLen;
        rErr    <= 1'b0;
      end
      if (wordDone) begin
        rRemain <= rRemain - 10'd1;
        rAddr   <= rAddr + 16'd4;
      end
      if (timeout) rErr <= 1'b1;
      if (state == WAIT_WD && iWrValid) oPwdata <= iWrData;
      if (state == ACCESS && iPready && !rWrite) oRdData <= iPrdata;
    end
  end
endmodule

// File: tb/tb_apb_burst_master.sv
// tb_apb_burst_master: directed self-checking bench for apb_burst_master with a small APB memory slave
module tb_apb_burst_master;
  logic        iClk = 1'b0;
  logic        iRst = 1'b1;
  logic        iCmdValid = 1'b0, iCmdWrite = 1'b0;
  logic [15:0] iCmdAddr = '0;
  logic [9:0]  iCmdLen = '0;
  logic        iWrValid = 1'b0, iRdReady = 1'b0, iPready = 1'b1;
  logic [31:0] iWrData = '0;
  logic [31:0] iPrdata;
  logic        oCmdReady, oWrReady, oRdValid, oPsel, oPenable, oPwrite, oBusy, oDone, oErr;
  logic [15:0] oPaddr;
  logic [31:0] oRdData, oPwdata;
  logic [31:0] mem [0:16383];
  logic [15:0] logA [$];
  logic [31:0] logD [$];
  int          setupCnt = 0;
  int          chkCnt = 0;
  int          errCnt = 0;
  int          n0, s0;

  apb_burst_master #(.TIMEOUT_CYC(4)) dut (
    .iClk(iClk), .iRst(iRst),
    .iCmdValid(iCmdValid), .oCmdReady(oCmdReady), .iCmdWrite(iCmdWrite), .iCmdAddr(iCmdAddr), .iCmdLen(iCmdLen),
    .iWrValid(iWrValid), .oWrReady(oWrReady), .iWrData(iWrData),
    .oRdValid(oRdValid), .iRdReady(iRdReady), .oRdData(oRdData),
    .oPsel(oPsel), .oPenable(oPenable), .oPwrite(oPwrite), .oPaddr(oPaddr), .oPwdata(oPwdata),
    .iPrdata(iPrdata), .iPready(iPready),
    .oBusy(oBusy), .oDone(oDone), .oErr(oErr)
  );

  always #5 iClk = ~iClk;

  assign iPrdata = mem[oPaddr[15:2]];

  always @(posedge iClk) begin
    if (oPsel && !oPenable) setupCnt <= setupCnt + 1;
    if (oPsel && oPenable && iPready) begin
      logA.push_back(oPaddr);
      logD.push_back(oPwdata);
      if (oPwrite) mem[oPaddr[15:2]] <= oPwdata;
    end
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    chkCnt++;
    if (got !== exp) begin
      errCnt++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge iClk);
    #1;
  endtask

  task automatic cmd(input logic wr, input logic [15:0] a, input logic [9:0] l);
    iCmdValid = 1'b1;
    iCmdWrite = wr;
    iCmdAddr  = a;
    iCmdLen   = l;
    step();
    iCmdValid = 1'b0;
  endtask

  // expects WAIT_WD on entry and iPready=1; leaves the DUT just after ACCESS
  task automatic wrWord(input logic [31:0] d, input logic [15:0] a);
    check("wd_ready", oWrReady, 1);
    iWrValid = 1'b1;
    iWrData  = d;
    step();
    iWrValid = 1'b0;
    check("wr_setup", {oPsel, oPenable, oPwrite}, 3'b101);
    check("wr_setup_addr", oPaddr, a);
    check("wr_pwdata", oPwdata, d);
    step();
    check("wr_access", {oPsel, oPenable}, 2'b11);
    check("wr_access_addr", oPaddr, a);
    step();
  endtask

  task automatic waitDone(input int maxCyc);
    int cyc = 0;
    while (!oDone && cyc < maxCyc) begin
      step();
      cyc++;
    end
    check("done_seen", oDone, 1);
  endtask

  initial begin
    repeat (3) step();
    iRst = 1'b0;
    check("rst_cmdready", oCmdReady, 1);
    check("rst_outs", {oWrReady, oRdValid, oPsel, oPenable, oPwrite, oBusy, oDone, oErr}, 8'h00);
    check("rst_paddr", oPaddr, 16'h0000);
    check("rst_pwdata", oPwdata, 0);
    check("rst_rddata", oRdData, 0);

    // T1: three-word write burst
    cmd(1'b1, 16'h4000, 10'd3);
    check("t1_busy", {oBusy, oCmdReady}, 2'b10);
    for (int i = 0; i < 3; i++) wrWord(32'hA + i, 16'h4000 + 16'(4 * i));
    check("t1_done", {oDone, oErr, oBusy, oPsel}, 4'b1010);
    step();
    check("t1_idle", {oDone, oBusy, oCmdReady}, 3'b001);

    // T2: control write then single-word read back
    cmd(1'b1, 16'h0004, 10'd1);
    wrWord(32'h200, 16'h0004);
    check("t2_wdone", oDone, 1);
    step();
    cmd(1'b0, 16'h0004, 10'd1);
    check("t2_setup", {oPsel, oPenable, oPwrite}, 3'b100);
    check("t2_addr", oPaddr, 16'h0004);
    step();
    check("t2_access", {oPsel, oPenable}, 2'b11);
    step();
    check("t2_rdvalid", {oRdValid, oPsel}, 2'b10);
    check("t2_rddata", oRdData, 32'h200);
    check("t2_nodone", oDone, 0);
    iRdReady = 1'b1;
    step();
    iRdReady = 1'b0;
    check("t2_done", oDone, 1);
    step();

    // T3: preload two words, then read with wait states and a stalled consumer
    cmd(1'b1, 16'h6000, 10'd2);
    wrWord(32'h11111111, 16'h6000);
    wrWord(32'h22222222, 16'h6004);
    step();
    iPready = 1'b0;
    cmd(1'b0, 16'h6000, 10'd2);
    check("t3_setup", {oPsel, oPenable}, 2'b10);
    step();
    check("t3_acc1", {oPsel, oPenable}, 2'b11);
    step();
    check("t3_acc2", {oPsel, oPenable}, 2'b11);
    check("t3_acc2_addr", oPaddr, 16'h6000);
    iPready = 1'b1;
    step();
    check("t3_hold_data", oRdData, 32'h11111111);
    s0 = setupCnt;
    for (int i = 0; i < 3; i++) begin
      check("t3_hold", {oRdValid, oPsel}, 2'b10);
      step();
    end
    check("t3_hold_stable", oRdData, 32'h11111111);
    check("t3_no_setup", setupCnt, s0);
    iRdReady = 1'b1;
    step();
    iRdReady = 1'b0;
    check("t3_setup2", {oPsel, oPenable}, 2'b10);
    check("t3_addr2", oPaddr, 16'h6004);
    step();
    step();
    check("t3_data2", oRdData, 32'h22222222);
    iRdReady = 1'b1;
    step();
    iRdReady = 1'b0;
    check("t3_done", oDone, 1);
    step();

    // T4: timeout abort on a write burst
    iPready = 1'b0;
    n0 = logA.size();
    cmd(1'b1, 16'h4000, 10'd5);
    iWrValid = 1'b1;
    iWrData  = 32'hDEAD;
    step();
    iWrValid = 1'b0;
    step();
    for (int i = 0; i < 3; i++) step();
    check("t4_acc4", {oPsel, oPenable, oDone}, 3'b110);
    step();
    check("t4_abort", {oDone, oErr, oPsel}, 3'b110);
    s0 = setupCnt;
    step();
    check("t4_idle", {oErr, oBusy, oCmdReady}, 3'b001);
    repeat (3) step();
    check("t4_no_xfer", logA.size(), n0);
    check("t4_no_setup", setupCnt, s0);
    iPready = 1'b1;

    // T5: zero-length no-op, then a clamped wrapping burst
    s0 = setupCnt;
    cmd(1'b1, 16'h1234, 10'd0);
    check("t5_len0_done", {oDone, oErr, oPsel}, 3'b100);
    step();
    check("t5_len0_noapb", setupCnt, s0);
    n0 = logA.size();
    iWrValid = 1'b1;
    iWrData  = 32'h5A5A5A5A;
    cmd(1'b1, 16'hFFF8, 10'h3FF);
    waitDone(2000);
    check("t5_err", oErr, 0);
    step();
    iWrValid = 1'b0;
    check("t5_count", logA.size() - n0, 512);
    if (logA.size() >= n0 + 512) begin
      check("t5_a0", logA[n0], 16'hFFF8);
      check("t5_a1", logA[n0 + 1], 16'hFFFC);
      check("t5_a2", logA[n0 + 2], 16'h0000);
      check("t5_alast", logA[n0 + 511], 16'h07F4);
      check("t5_d", logD[n0 + 511], 32'h5A5A5A5A);
    end

    // T6: reset in the middle of ACCESS
    iPready = 1'b0;
    cmd(1'b0, 16'h6000, 10'd1);
    step();
    check("t6_access", {oPsel, oPenable}, 2'b11);
    iRst = 1'b1;
    step();
    iRst = 1'b0;
    check("t6_rst", {oPsel, oBusy, oCmdReady, oDone}, 4'b0010);
    step();
    check("t6_nodone", oDone, 0);
    iPready = 1'b1;
    cmd(1'b0, 16'h6004, 10'd1);
    check("t6_setup", {oPsel, oPenable}, 2'b10);
    check("t6_addr", oPaddr, 16'h6004);
    step();
    step();
    check("t6_data", {oRdValid, oRdData}, {1'b1, 32'h22222222});
    iRdReady = 1'b1;
    step();
    iRdReady = 1'b0;
    check("t6_done", oDone, 1);
    step();

    $display("Simulation finished: %0d checks, %0d errors", chkCnt, errCnt);
    $finish;
  end
endmodule
